// File: rtl/ann_argmax.sv
// rtl/ann_argmax.sv - streaming signed argmax over one frame of N_OUT neuron results
// Optional ARGMAX_SCORE_EN adds the max_score output carrying the winning value.
module ann_argmax #(
    parameter int DW    = 8,
    parameter int N_OUT = 10,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 class_valid,
    output logic [IDX_W-1:0]     class_idx,
    output logic                 err
`ifdef ARGMAX_SCORE_EN
    ,
    output logic signed [DW-1:0] max_score
`endif
);

    localparam int CNT_W = (N_OUT > 2) ? $clog2(N_OUT) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic signed [DW-1:0] r_max;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_class_idx;
    logic                 r_err;

    logic                 w_xfer;
    logic                 w_last;
    logic                 w_take;
    logic signed [DW-1:0] w_max_next;
    logic [IDX_W-1:0]     w_idx_next;
    logic                 w_err_next;

    assign w_xfer = in_valid && (r_state == S_COLLECT);
    assign w_last = (r_cnt == CNT_W'(N_OUT - 1));
    // Strictly-greater replacement keeps the lowest index on ties.
    assign w_take     = (r_cnt == '0) || (in_data > r_max);
    assign w_max_next = w_take ? in_data : r_max;
    assign w_idx_next = w_take ? IDX_W'(r_cnt) : r_idx;

    assign w_err_next = (start && (r_state != S_IDLE)) ||
                        (in_valid && (r_state != S_COLLECT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_max   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_COLLECT;
                        r_cnt   <= '0;
                        r_max   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_max <= w_max_next;
                        r_idx <= w_idx_next;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The result is captured on the last transfer so it is already valid in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_class_idx <= '0;
        end else if (w_xfer && w_last) begin
            r_class_idx <= w_idx_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

`ifdef ARGMAX_SCORE_EN
    logic signed [DW-1:0] r_score;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_score <= '0;
        end else if (w_xfer && w_last) begin
            r_score <= w_max_next;
        end
    end

    assign max_score = r_score;
`endif

    assign in_ready    = (r_state == S_COLLECT);
    assign busy        = (r_state != S_IDLE);
    assign class_valid = (r_state == S_DONE);
    assign class_idx   = r_class_idx;
    assign err         = r_err;

endmodule

// File: tb/tb_ann_argmax.sv
// tb/tb_ann_argmax.sv - scoreboard bench for ann_argmax with N_OUT=4
module tb_ann_argmax;

    localparam int DW    = 8;
    localparam int N_OUT = 4;
    localparam int IDX_W = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_ready;
    logic                 busy;
    logic                 class_valid;
    logic [IDX_W-1:0]     class_idx;
    logic                 err;
`ifdef ARGMAX_SCORE_EN
    logic signed [DW-1:0] max_score;
`endif

    int errors = 0;
    int checks = 0;
    int cv_count = 0;
    int exp_idx_q[$];
    int exp_score_q[$];

    always #5 clk = ~clk;

    ann_argmax #(.DW(DW), .N_OUT(N_OUT), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .class_valid (class_valid),
        .class_idx   (class_idx),
        .err         (err)
`ifdef ARGMAX_SCORE_EN
        ,
        .max_score   (max_score)
`endif
    );

    // Result monitor: pops the scoreboard on every class_valid cycle.
    always @(negedge clk) begin
        if (class_valid) begin
            int e_idx;
            int e_score;
            cv_count++;
            checks++;
            if (exp_idx_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_class_valid: got class_idx=%0d, required no pulse", class_idx);
            end else begin
                e_idx   = exp_idx_q.pop_front();
                e_score = exp_score_q.pop_front();
                if (class_idx !== IDX_W'(e_idx)) begin
                    errors++;
                    $display("FAIL class_idx: got %0d, required %0d", class_idx, e_idx);
                end
`ifdef ARGMAX_SCORE_EN
                checks++;
                if (max_score !== DW'(e_score)) begin
                    errors++;
                    $display("FAIL max_score: got %0d, required %0d", max_score, e_score);
                end
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int d[4]);
        int best;
        int bi;
        best = d[0];
        bi   = 0;
        for (int i = 1; i < N_OUT; i++) begin
            if (d[i] > best) begin
                best = d[i];
                bi   = i;
            end
        end
        exp_idx_q.push_back(bi);
        exp_score_q.push_back(best);
    endtask

    // Starts a frame, sends four elements with `gap` idle cycles between them,
    // checks the DONE cycle and returns in the first IDLE cycle.
    task automatic run_frame(input int d[4], input int gap, input string name);
        push_expected(d);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_after_start: got %0b, required 1", name, in_ready);
        end
        for (int i = 0; i < N_OUT; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(d[i]);
            step();
            in_valid = 1'b0;
            if (i < N_OUT - 1) begin
                for (int g = 0; g < gap; g++) begin
                    checks++;
                    if (in_ready !== 1'b1 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s_gap_ready: got in_ready=%0b busy=%0b, required 1 1", name, in_ready, busy);
                    end
                    step();
                end
            end
        end
        checks++;
        if (class_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_cycle: got valid=%0b ready=%0b busy=%0b, required 1 0 1",
                     name, class_valid, in_ready, busy);
        end
        step();
        checks++;
        if (class_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_back_to_idle: got valid=%0b busy=%0b, required 0 0", name, class_valid, busy);
        end
    endtask

    task automatic test_reset();
        int cv0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            step();
            checks++;
            if ({in_ready, busy, class_valid, class_idx, err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got ready=%0b busy=%0b valid=%0b idx=%0d err=%0b, required all 0",
                         in_ready, busy, class_valid, class_idx, err);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        cv0      = cv_count;
        repeat (5) step();
        checks++;
        if (cv_count != cv0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got pulses=%0d busy=%0b err=%0b, required 0 0 0", cv_count - cv0, busy, err);
        end
    endtask

    task automatic test_basic();
        run_frame('{5, -3, 17, 2}, 0, "basic");
        step();
        checks++;
        if (class_idx !== 2'd2) begin
            errors++;
            $display("FAIL basic_idx_held: got %0d, required 2", class_idx);
        end
    endtask

    task automatic test_back_to_back();
        run_frame('{-8, -2, -2, -128}, 0, "ties");
        run_frame('{127, 127, 0, 0}, 0, "b2b");
    endtask

    task automatic test_gapped();
        run_frame('{1, 9, 4, 9}, 3, "gapped");
    endtask

    task automatic test_violations();
        in_valid = 1'b1;
        in_data  = 8'sd50;
        step();
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid_err: got err=%0b busy=%0b, required 1 0", err, busy);
        end
        step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: got %0b, required 0", err);
        end

        // start in COLLECT: ignored, frame result unchanged
        push_expected('{3, 10, -5, 7});
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'sd3;  step();
        in_valid = 1'b1; in_data = 8'sd10; step();
        in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL collect_start_err: got err=%0b ready=%0b, required 1 1", err, in_ready);
        end
        in_valid = 1'b1; in_data = -8'sd5; step();
        in_valid = 1'b1; in_data = 8'sd7;  step();
        in_valid = 1'b0;
        step();

        // start with in_valid in IDLE: start honoured, data dropped
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'sd99;
        push_expected('{-5, -2, -3, -4});
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_with_valid: got err=%0b ready=%0b, required 1 1", err, in_ready);
        end
        in_valid = 1'b1; in_data = -8'sd5; step();
        in_valid = 1'b1; in_data = -8'sd2; step();
        in_valid = 1'b1; in_data = -8'sd3; step();
        in_valid = 1'b1; in_data = -8'sd4; step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_midframe();
        int cv0;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'sd50; step();
        in_valid = 1'b1; in_data = 8'sd60; step();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (class_idx !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got idx=%0d busy=%0b ready=%0b, required 0 0 0", class_idx, busy, in_ready);
        end
        step();
        rst = 1'b1;
        step();
        cv0 = cv_count;
        run_frame('{0, 0, 0, 1}, 0, "after_reset");
        repeat (3) step();
        checks++;
        if (cv_count - cv0 != 1) begin
            errors++;
            $display("FAIL after_reset_pulses: got %0d, required 1", cv_count - cv0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_gapped();
        test_violations();
        test_reset_midframe();
        repeat (2) step();
        checks++;
        if (exp_idx_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_idx_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
